// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS transfer out, one-cycle response pulse.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR
  } state_t;

  state_t                r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_W-1:0]     r_paddr;
  logic [DATA_W-1:0]     r_pwdata;
  logic [DATA_W/8-1:0]   r_pstrb;
  logic [2:0]            r_pprot;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_W-1:0]     r_rsp_rdata;

  logic w_misaligned;
  logic w_timeout;

  // Ready is forced low while reset is held so nothing is accepted on a reset edge.
  assign cmd_ready    = (r_state == S_IDLE) && !preset;
  assign w_misaligned = |cmd_addr[1:0];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counts completed ACCESS cycles; zero during the first ACCESS cycle.
  always_ff @(posedge pclk) begin
    if (preset || r_state != S_ACCESS) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !pready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_misaligned) begin
              r_state     <= S_ERR;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state  <= S_SETUP;
              r_psel   <= 1'b1;
              r_pwrite <= cmd_write;
              r_paddr  <= cmd_addr;
              r_pprot  <= cmd_prot;
              r_pwdata <= cmd_write ? cmd_wdata : '0;
              r_pstrb  <= cmd_write ? cmd_strb : '0;
            end
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (pready || w_timeout) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pready ? pslverr : 1'b1;
            r_rsp_rdata <= (pready && !pslverr && !r_pwrite) ? prdata : '0;
          end
        end
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign pprot     = r_pprot;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
